// File: rtl/i2c_slave.sv
// Byte-level I2C target: START/STOP detection, 7-bit address match, byte RX/TX
// through host-side read/write registers, with SCL stretching when a register is not serviced.
module i2c_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slave_en,
  input  logic [6:0] own_addr,
  input  logic       rd_clr,
  input  logic       wr_rdy,
  input  logic [7:0] byte_wr_i,
  output logic [7:0] byte_rd_o,
  output logic       rd_reg_full,
  output logic       wr_reg_empty,
  output logic       trans_start,
  output logic       addr_match,
  output logic       trans_dir,
  output logic       get_nack,
  output logic       trans_stop,
  output logic       bus_err,
  output logic       byte_wait,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_h_q, sda_h_q;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic                   seen_q, seen_d, ack_q, ack_d, hold_q, hold_d, sda_q, sda_d;
  logic                   match_q, match_d, dir_q, dir_d;
  logic                   rd_full_q, rd_full_d, wr_empty_q, wr_empty_d;
  logic                   start_q, start_d, stop_q, stop_d, berr_q, berr_d, nack_q, nack_d;
  logic [7:0]             rd_q, rd_d, wr_q, wr_d, shift_q, shift_d, wr_data;
  logic                   wr_avail, rx_free, do_load, commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_h_q    <= 1'b1;
      sda_h_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_h_q    <= scl_sync_q[SYNC_STAGES-1];
      sda_h_q    <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_h_q;
  assign scl_fall  = ~scl_s & scl_h_q;
  assign start_det = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop_det  = scl_s & scl_h_q & ~sda_h_q & sda_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      seen_q     <= 1'b0;
      ack_q      <= 1'b0;
      hold_q     <= 1'b0;
      sda_q      <= 1'b1;
      match_q    <= 1'b0;
      dir_q      <= 1'b0;
      rd_full_q  <= 1'b0;
      wr_empty_q <= 1'b1;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      berr_q     <= 1'b0;
      nack_q     <= 1'b0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      seen_q     <= seen_d;
      ack_q      <= ack_d;
      hold_q     <= hold_d;
      sda_q      <= sda_d;
      match_q    <= match_d;
      dir_q      <= dir_d;
      rd_full_q  <= rd_full_d;
      wr_empty_q <= wr_empty_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      berr_q     <= berr_d;
      nack_q     <= nack_d;
      rd_q       <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    wr_q    <= wr_d;
  end

  // Bits are sampled on SCL rise but counted on the following fall, so the
  // rise preceding a STOP or repeated START never looks like a partial byte.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    seen_d     = seen_q;
    ack_d      = ack_q;
    hold_d     = hold_q;
    sda_d      = sda_q;
    match_d    = match_q;
    dir_d      = dir_q;
    rd_full_d  = rd_full_q;
    wr_empty_d = wr_empty_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    shift_d    = shift_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    berr_d     = 1'b0;
    nack_d     = 1'b0;
    do_load    = 1'b0;
    commit     = 1'b0;
    wr_avail   = !wr_empty_q || wr_rdy;
    wr_data    = wr_empty_q ? byte_wr_i : wr_q;
    rx_free    = !rd_full_q || rd_clr;
    if (rd_clr) rd_full_d = 1'b0;
    if (wr_rdy && wr_empty_q) begin
      wr_d       = byte_wr_i;
      wr_empty_d = 1'b0;
    end
    if (!slave_en) begin
      state_d  = IDLE;
      hold_d   = 1'b0;
      sda_d    = 1'b1;
      match_d  = 1'b0;
      bitcnt_d = '0;
    end else if (stop_det) begin
      state_d  = IDLE;
      stop_d   = match_q;
      berr_d   = match_q && (bitcnt_q != 3'd0);
      match_d  = 1'b0;
      hold_d   = 1'b0;
      sda_d    = 1'b1;
      bitcnt_d = '0;
    end else if (start_det) begin
      state_d  = ADDR;
      start_d  = 1'b1;
      berr_d   = match_q && (bitcnt_q != 3'd0);
      match_d  = 1'b0;
      hold_d   = 1'b0;
      sda_d    = 1'b1;
      seen_d   = 1'b0;
      bitcnt_d = '0;
    end else begin
      if (scl_rise) seen_d = 1'b1;
      else if (scl_fall) seen_d = 1'b0;
      case (state_q)
        ADDR: begin
          if (scl_rise) shift_d = {shift_q[6:0], sda_s};
          if (scl_fall && seen_q) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (shift_q[7:1] == own_addr) begin
                match_d = 1'b1;
                dir_d   = shift_q[0];
                sda_d   = 1'b0;
                state_d = ADDR_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (dir_q) begin
              state_d = TX;
              do_load = 1'b1;
            end else begin
              sda_d   = 1'b1;
              state_d = RX;
            end
          end
        end
        RX: begin
          if (scl_rise) shift_d = {shift_q[6:0], sda_s};
          if (hold_q) begin
            commit = rx_free;
          end else if (scl_fall && seen_q) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              if (rx_free) commit = 1'b1;
              else hold_d = 1'b1;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_d   = 1'b1;
            state_d = RX;
          end
        end
        TX: begin
          if (hold_q) begin
            do_load = 1'b1;
          end else if (scl_fall) begin
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              sda_d   = 1'b1;
              ack_d   = 1'b0;
              state_d = TX_ACK;
            end else begin
              sda_d   = shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              nack_d  = 1'b1;
              state_d = WAIT_STOP;
            end else begin
              ack_d = 1'b1;
            end
          end else if (scl_fall && ack_q) begin
            ack_d   = 1'b0;
            state_d = TX;
            do_load = 1'b1;
          end
        end
        default: ;
      endcase
      if (commit) begin
        rd_d      = shift_q;
        rd_full_d = 1'b1;
        sda_d     = 1'b0;
        hold_d    = 1'b0;
        state_d   = RX_ACK;
      end
      // A wr_rdy arriving during the stretch is consumed straight from byte_wr_i.
      if (do_load) begin
        if (wr_avail) begin
          shift_d    = {wr_data[6:0], 1'b0};
          sda_d      = wr_data[7];
          wr_empty_d = 1'b1;
          hold_d     = 1'b0;
          bitcnt_d   = '0;
        end else begin
          hold_d = 1'b1;
          sda_d  = 1'b1;
        end
      end
    end
  end

  assign scl_o        = ~hold_q;
  assign sda_o        = sda_q;
  assign byte_wait    = hold_q;
  assign byte_rd_o    = rd_q;
  assign rd_reg_full  = rd_full_q;
  assign wr_reg_empty = wr_empty_q;
  assign trans_start  = start_q;
  assign addr_match   = match_q;
  assign trans_dir    = dir_q;
  assign get_nack     = nack_q;
  assign trans_stop   = stop_q;
  assign bus_err      = berr_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bus-master model drives directed transfers; expected
// status pulses and received bytes are queued and matched by an independent monitor.
module tb_i2c_slave;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       slave_en = 1'b1;
  logic [6:0] own_addr = 7'h25;
  logic       rd_clr, wr_rdy;
  logic [7:0] byte_wr_i;
  logic [7:0] byte_rd_o;
  logic       rd_reg_full, wr_reg_empty, trans_start, addr_match, trans_dir;
  logic       get_nack, trans_stop, bus_err, byte_wait;
  logic       scl_i, sda_i, scl_o, sda_o;
  logic       scl_m = 1'b1, sda_m = 1'b1;

  assign scl_i = scl_m & scl_o;
  assign sda_i = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .slave_en(slave_en), .own_addr(own_addr),
    .rd_clr(rd_clr), .wr_rdy(wr_rdy), .byte_wr_i(byte_wr_i), .byte_rd_o(byte_rd_o),
    .rd_reg_full(rd_reg_full), .wr_reg_empty(wr_reg_empty), .trans_start(trans_start),
    .addr_match(addr_match), .trans_dir(trans_dir), .get_nack(get_nack),
    .trans_stop(trans_stop), .bus_err(bus_err), .byte_wait(byte_wait),
    .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Event vector bits: {trans_start, trans_stop, get_nack, bus_err, new_rx_byte}
  localparam logic [4:0] EV_START = 5'b10000, EV_STOP = 5'b01000, EV_NACK = 5'b00100,
                         EV_BERR  = 5'b00010, EV_RX   = 5'b00001;
  typedef struct packed { logic [4:0] ev; logic [7:0] d; } exp_t;
  exp_t exp_q[$];

  task automatic push(input logic [4:0] ev, input logic [7:0] d);
    exp_q.push_back({ev, d});
  endtask

  logic clr_s = 1'b0, full_s = 1'b0;
  int   low_cnt = 0, am_cnt = 0, cur_stretch = 0, max_stretch = 0;

  always @(posedge clk) begin
    clr_s  <= rd_clr;
    full_s <= rd_reg_full;
  end

  initial begin
    forever begin
      logic [4:0] obs;
      exp_t       e;
      @(negedge clk);
      obs = {trans_start, trans_stop, get_nack, bus_err, rd_reg_full && (!full_s || clr_s)};
      if (obs != 5'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {27'b0, obs}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", {27'b0, obs}, {27'b0, e.ev});
          if (obs[0]) chk("rx_byte", {24'b0, byte_rd_o}, {24'b0, e.d});
        end
      end
      if (!scl_o) cur_stretch++;
      else cur_stretch = 0;
      if (cur_stretch > max_stretch) max_stretch = cur_stretch;
      if (!scl_o || !sda_o) low_cnt++;
      if (addr_match) am_cnt++;
    end
  end

  logic [7:0] tx_q[$];
  bit         auto_clr = 1'b1;
  int         clr_req = 0, clr_done = 0;

  initial begin
    rd_clr = 1'b0; wr_rdy = 1'b0; byte_wr_i = 8'h00;
    forever begin
      @(negedge clk);
      rd_clr = 1'b0;
      wr_rdy = 1'b0;
      if (clr_req != clr_done) begin
        rd_clr = 1'b1;
        clr_done++;
      end else if (auto_clr && rd_reg_full) begin
        rd_clr = 1'b1;
      end
      if (!rst && wr_reg_empty && tx_q.size() > 0) begin
        byte_wr_i = tx_q.pop_front();
        wr_rdy = 1'b1;
      end
    end
  end

  task automatic wt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_hi();
    int n = 0;
    scl_m = 1'b1;
    while (scl_i !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("scl_release_timeout", n, 0);
  endtask

  task automatic start_c();
    wt(2); sda_m = 1'b1; wt(T); scl_hi(); wt(T); sda_m = 1'b0; wt(T); scl_m = 1'b0;
  endtask

  task automatic stop_c();
    wt(2); sda_m = 1'b0; wt(T); scl_hi(); wt(T); sda_m = 1'b1; wt(T);
  endtask

  task automatic wbit(input logic b);
    wt(2); sda_m = b; wt(T); scl_hi(); wt(T); scl_m = 1'b0;
  endtask

  task automatic rbit(output logic b);
    wt(2); sda_m = 1'b1; wt(T); scl_hi(); wt(T/2); b = sda_i; wt(T/2); scl_m = 1'b0;
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) rbit(d[i]);
    wbit(ack);
  endtask

  logic [7:0] rx;
  logic       ack, b0, b1, b2;
  int         low0, am0, bad, n;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    wt(3);
    chk("reset_outputs", {13'b0, scl_o, sda_o, wr_reg_empty, byte_rd_o, rd_reg_full, trans_start,
        addr_match, trans_dir, get_nack, trans_stop, bus_err, byte_wait}, {13'b0, 3'b111, 16'h0});
    rst = 1'b0;
    wt(5);
    chk("idle_lines", {30'b0, scl_o, sda_o}, 32'h3);

    // Write 0xA5, 0x3C to own address
    push(EV_START, 8'h00); push(EV_RX, 8'hA5); push(EV_RX, 8'h3C); push(EV_STOP, 8'h00);
    start_c();
    wbyte(8'h4A, ack); chk("wr_addr_ack", ack, 0);
    wt(2);
    chk("wr_addr_match", addr_match, 1);
    chk("wr_trans_dir", trans_dir, 0);
    wbyte(8'hA5, ack); chk("wr_byte1_ack", ack, 0);
    wbyte(8'h3C, ack); chk("wr_byte2_ack", ack, 0);
    stop_c();
    wt(10);
    chk("wr_match_after_stop", addr_match, 0);

    // Foreign address: no drive, never addressed
    low0 = low_cnt; am0 = am_cnt;
    push(EV_START, 8'h00);
    start_c();
    wbyte(8'h4C, ack); chk("foreign_addr_nack", ack, 1);
    stop_c();
    wt(10);
    chk("foreign_no_drive", low_cnt - low0, 0);
    chk("foreign_no_match", am_cnt - am0, 0);

    // Read 0x81, 0x7E; master ACKs then NACKs
    tx_q.push_back(8'h81); tx_q.push_back(8'h7E);
    push(EV_START, 8'h00); push(EV_NACK, 8'h00); push(EV_STOP, 8'h00);
    start_c();
    wbyte(8'h4B, ack); chk("rd_addr_ack", ack, 0);
    chk("rd_trans_dir", trans_dir, 1);
    rbyte(rx, 1'b0); chk("rd_byte1", rx, 8'h81);
    rbyte(rx, 1'b1); chk("rd_byte2", rx, 8'h7E);
    wt(6);
    chk("rd_sda_released", sda_o, 1);
    stop_c();
    wt(10);

    // Read with the write register supplied 50 clk into the stretch
    push(EV_START, 8'h00); push(EV_NACK, 8'h00); push(EV_STOP, 8'h00);
    fork
      begin
        start_c();
        wbyte(8'h4B, ack); chk("stretch_addr_ack", ack, 0);
        rbyte(rx, 1'b1);
        chk("stretch_first_bit_msb", rx[7], 1);
        chk("stretch_byte", rx, 8'hC3);
      end
      begin
        n = 0;
        while (!byte_wait && n < 3000) begin @(negedge clk); n++; end
        chk("stretch_seen", byte_wait, 1);
        bad = 0;
        repeat (50) begin
          @(negedge clk);
          if (!byte_wait || scl_i) bad++;
        end
        chk("stretch_byte_wait_held", bad, 0);
        tx_q.push_back(8'hC3);
      end
    join
    stop_c();
    wt(10);
    chk("stretch_len_ge_50", max_stretch >= 50, 1);

    // Write with rd_reg_full left set: second byte waits for rd_clr
    auto_clr = 1'b0;
    push(EV_START, 8'h00); push(EV_RX, 8'h11); push(EV_RX, 8'h22); push(EV_STOP, 8'h00);
    fork
      begin
        start_c();
        wbyte(8'h4A, ack); chk("full_addr_ack", ack, 0);
        wbyte(8'h11, ack); chk("full_byte1_ack", ack, 0);
        wbyte(8'h22, ack); chk("full_byte2_ack", ack, 0);
      end
      begin
        n = 0;
        while (!(byte_wait && rd_reg_full) && n < 3000) begin @(negedge clk); n++; end
        wt(30);
        chk("full_hold_byte", byte_rd_o, 8'h11);
        chk("full_scl_held", scl_o, 0);
        clr_req++;
      end
    join
    chk("full_second_byte", byte_rd_o, 8'h22);
    chk("full_still_full", rd_reg_full, 1);
    stop_c();
    clr_req++;
    wt(10);
    auto_clr = 1'b1;
    chk("full_cleared", rd_reg_full, 0);

    // Repeated START after 3 data bits, then a normal transfer
    push(EV_START, 8'h00); push(EV_START | EV_BERR, 8'h00); push(EV_RX, 8'h5A);
    push(EV_STOP, 8'h00);
    start_c();
    wbyte(8'h4A, ack); chk("berr_addr_ack", ack, 0);
    wbit(1'b1); wbit(1'b0); wbit(1'b1);
    start_c();
    wt(2);
    chk("berr_match_cleared", addr_match, 0);
    wbyte(8'h4A, ack); chk("berr_readdr_ack", ack, 0);
    wbyte(8'h5A, ack); chk("berr_byte_ack", ack, 0);
    stop_c();
    wt(10);

    // Reset in the middle of a read byte
    tx_q.push_back(8'h00); tx_q.push_back(8'h12);
    push(EV_START, 8'h00);
    start_c();
    wbyte(8'h4B, ack); chk("rst_addr_ack", ack, 0);
    rbit(b0); rbit(b1); rbit(b2);
    chk("rst_bits", {b0, b1, b2}, 3'b000);
    wt(6);
    chk("rst_pre_wr_loaded", wr_reg_empty, 0);
    chk("rst_pre_sda_driven", sda_o, 0);
    rst = 1'b1;
    wt(1);
    chk("rst_mid_outputs", {13'b0, scl_o, sda_o, wr_reg_empty, byte_rd_o, rd_reg_full, trans_start,
        addr_match, trans_dir, get_nack, trans_stop, bus_err, byte_wait}, {13'b0, 3'b111, 16'h0});
    rst = 1'b0;
    stop_c();
    wt(20);

    chk("events_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
